// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered ALU result stage for the pipelined MIPS datapath. Computes
//   AND/OR/ADD/SUB/SLT on WIDTH-bit operands. Each result is written into a
//   2-entry output buffer with valid/ready handshakes on both sides, so the
//   stage can absorb one cycle of downstream stall. An illegal op code
//   re-issues the last legal result and flags the entry as illegal.
//
//   Optional feature: define ALU_OVF_EN to add the ovf port and a per-entry
//   signed-overflow flag.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/op valid this cycle
//   in_ready   out  stage can accept (count < 2)
//   a, b       in   WIDTH-bit operands
//   op         in   3-bit ALU control (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//   out_valid  out  buffer head valid (count != 0)
//   out_ready  in   consumer takes the head this cycle
//   result     out  head result
//   zero       out  head result == 0
//   illegal    out  head entry came from an illegal op
//   ovf        out  head signed overflow (ALU_OVF_EN only)
module alu_result_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  // Buffer storage and bookkeeping
  logic [WIDTH-1:0] res_q [2];
  logic [1:0]       zero_q;
  logic [1:0]       ill_q;
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [WIDTH-1:0] last_legal;

  // Combinational ALU
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = ($signed(a) < $signed(b));

  always_comb begin
    alu_res   = last_legal;
    alu_legal = 1'b1;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: begin
        alu_res   = last_legal;
        alu_legal = 1'b0;
      end
    endcase
  end

`ifdef ALU_OVF_EN
  logic [1:0] ovf_q;
  logic       alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
      OP_SUB:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // Handshakes: in_ready comes only from the registered count
  logic push;
  logic pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        res_q[i] <= '0;
      end
      // Reset entries hold result 0, so their stored zero flag is 1
      zero_q     <= '1;
      ill_q      <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= '0;
      last_legal <= '0;
    end else begin
      if (push) begin
        res_q[tail]  <= alu_res;
        zero_q[tail] <= (alu_res == '0);
        ill_q[tail]  <= ~alu_legal;
        tail         <= ~tail;
        if (alu_legal) begin
          last_legal <= alu_res;
        end
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (push) begin
      ovf_q[tail] <= alu_ovf;
    end
  end

  assign ovf = ovf_q[head];
`endif

  assign result  = res_q[head];
  assign zero    = zero_q[head];
  assign illegal = ill_q[head];

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    logic         v;
    int unsigned  cyc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_last = '0;
  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  bit           rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: signed-integer arithmetic on 64-bit values
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] o, input logic [W-1:0] last);
    exp_t   e;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.v = 1'b0; e.ill = 1'b0; e.cyc = 0;
    case (o)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: begin s = sx + sy; e.res = W'(s); e.v = (s > MAXS) || (s < MINS); end
      3'b110: begin s = sx - sy; e.res = W'(s); e.v = (s > MAXS) || (s < MINS); end
      3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
      default: begin e.res = last; e.ill = 1'b1; end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Recorder: every accepted input produces an expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e = model(a, b, op, m_last);
      e.cyc = cyc;
      q.push_back(e);
      if (!e.ill) m_last = e.res;
    end
  end

  // Monitor: entries recorded in earlier cycles are the buffer contents
  always @(negedge clk) begin
    int n;
    if (rst_n) begin
      n = 0;
      foreach (q[i]) if (q[i].cyc < cyc) n++;
      check("out_valid", 32'(out_valid), 32'(n != 0));
      check("in_ready", 32'(in_ready), 32'(n < 2));
      if (n != 0) begin
        check("result", result, q[0].res);
        check("zero", 32'(zero), 32'(q[0].z));
        check("illegal", 32'(illegal), 32'(q[0].ill));
`ifdef ALU_OVF_EN
        check("ovf", 32'(ovf), 32'(q[0].v));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    bit acc = 0;
    a = x; b = y; op = o; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
`ifdef ALU_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add and signed compares
    out_ready = 1'b1;
    issue(32'd5, 32'd3, 3'b010);
    idle(2);
    issue(32'd3, 32'd3, 3'b110);
    issue(32'hFFFFFFFF, 32'd1, 3'b111);
    issue(32'd1, 32'hFFFFFFFF, 3'b111);
    idle(2);

    // Stall: two accepted, third held until out_ready rises
    out_ready = 1'b0;
    issue(32'hF0, 32'h3C, 3'b000);
    issue(32'hF0, 32'h0F, 3'b001);
    a = 32'd1; b = 32'd1; op = 3'b010; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(32'd1, 32'd1, 3'b010);
    idle(3);

    // Illegal op re-issues last legal result
    issue(32'd7, 32'd2, 3'b010);
    issue(32'd0, 32'd0, 3'b011);
    issue(32'd1, 32'd1, 3'b010);
    idle(2);

    // Streaming then reset mid-stream
    for (int i = 0; i < 8; i++) issue($urandom, $urandom, 3'b010);
    a = 32'd9; b = 32'd9; op = 3'b010; in_valid = 1'b1;
    rst_n = 1'b0;
    q.delete();
    m_last = '0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'h55, 32'hAA, 3'b101);
    idle(2);

    // Overflow boundaries
    issue(32'h7FFFFFFF, 32'd1, 3'b010);
    issue(32'h80000000, 32'd1, 3'b110);
    issue(32'd1, 32'd1, 3'b010);
    issue(32'h80000000, 32'h80000000, 3'b010);
    idle(2);

    // Randomized traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        2: ra = 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 1) != 0) ? $urandom : ra;
      issue(ra, rb, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
